calc_entry: RTL and testbench

Keystroke-driven operand entry and result controller for the four-digit BCD calculator. It consumes decoded key codes from the PS/2 keyboard stage, owns the A and B operand registers, and selects add or subtract. It latches the result from the external BCD adder and subtractor chains and drives the four digit inputs of the seven-segment display stage.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_entry_if.sv | 30 +++
 rtl/bcd_entry_reg.sv | 29 ++
 rtl/calc_entry.sv | 148 ++++++++++++++
 tb/tb_calc_entry.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the BCD calculator entry controller.
// Holds key codes, display digit codes and the controller state encoding.
package calc_pkg;
  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_EQ   = 4'hC;
  localparam logic [3:0] KEY_CLR  = 4'hD;
  localparam logic [3:0] KEY_BS   = 4'hE;
  localparam logic [3:0] KEY_NONE = 4'hF;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, SHOW_RES, SHOW_ERR} state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB);
  endfunction
endpackage

// File: rtl/calc_entry_if.sv
// Bus between the calculator entry controller and its surroundings.
//   key_i/key_valid_i : decoded keystroke from the keyboard stage
//   sum_i/carry_i     : external BCD adder chain result (A+B)
//   diff_i/borrow_i   : external BCD subtractor chain result (A-B)
//   a_o/b_o/sub_o     : registered operands and selected operation
//   dig*_o            : display digit codes for the seven-segment stage
interface calc_entry_if;
  logic [3:0]  key_i;
  logic        key_valid_i;
  logic [15:0] sum_i;
  logic        carry_i;
  logic [15:0] diff_i;
  logic        borrow_i;
  logic [15:0] a_o;
  logic [15:0] b_o;
  logic        sub_o;
  logic [3:0]  dig1_o, dig10_o, dig100_o, dig1000_o;

  // slave: the entry controller
  modport slave (
    input  key_i, key_valid_i, sum_i, carry_i, diff_i, borrow_i,
    output a_o, b_o, sub_o, dig1_o, dig10_o, dig100_o, dig1000_o
  );

  // master: keyboard stage, arithmetic chains and display
  modport master (
    output key_i, key_valid_i, sum_i, carry_i, diff_i, borrow_i,
    input  a_o, b_o, sub_o, dig1_o, dig10_o, dig100_o, dig1000_o
  );
endinterface

// File: rtl/bcd_entry_reg.sv
// Four-digit BCD operand register.
//   clk/rst   : clock, synchronous active-high reset
//   clr       : synchronous clear to zero
//   load_en   : parallel load of load_val
//   shift_en  : shift digit in at the ones position (dropped when full)
//   bs_en     : backspace, shift right dropping the ones digit
//   q/full    : register value; full when the thousands digit is nonzero
// Priority: reset/clear > load > shift > backspace.
module bcd_entry_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load_en,
  input  logic [15:0] load_val,
  input  logic        shift_en,
  input  logic [3:0]  digit,
  input  logic        bs_en,
  output logic [15:0] q,
  output logic        full
);
  assign full = (q[15:12] != 4'h0);

  always_ff @(posedge clk) begin
    if (rst || clr)            q <= '0;
    else if (load_en)          q <= load_val;
    else if (shift_en && !full) q <= {q[11:0], digit};
    else if (bs_en)            q <= {4'h0, q[15:4]};
  end
endmodule

// File: rtl/calc_entry.sv
// Keystroke-driven operand entry and result controller for a 4-digit BCD
// calculator. Owns operands A and B, the add/subtract selection and the
// result register, and decodes the displayed value with leading-zero blanking.
//   clk_i/rst_i : clock, synchronous active-high reset
//   bus         : key input, arithmetic chain results, operands and display
module calc_entry
  import calc_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  calc_entry_if.slave  bus
);
  state_t      state, next;
  logic [15:0] a, b, res;
  logic        a_full, b_full;
  logic        sub, b_started;

  logic        kv, dig, op, clr_all, err;
  logic        a_shift, a_bs, a_load, b_shift, b_bs, b_clr;
  logic        set_sub, set_bstart, clr_bstart, cap_res;
  logic [15:0] a_load_val;

  assign kv      = bus.key_valid_i;
  assign dig     = is_digit(bus.key_i);
  assign op      = is_op(bus.key_i);
  assign clr_all = kv && (bus.key_i == KEY_CLR);
  assign err     = sub ? bus.borrow_i : bus.carry_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ENTER_A;
    else       state <= next;
  end

  always_comb begin
    next       = state;
    a_shift    = 1'b0;
    a_bs       = 1'b0;
    a_load     = 1'b0;
    a_load_val = res;
    b_shift    = 1'b0;
    b_bs       = 1'b0;
    b_clr      = 1'b0;
    set_sub    = 1'b0;
    set_bstart = 1'b0;
    clr_bstart = 1'b0;
    cap_res    = 1'b0;
    if (clr_all) begin
      next = ENTER_A;
    end else if (kv) begin
      unique case (state)
        ENTER_A: begin
          if (dig) a_shift = 1'b1;
          else if (op) begin
            set_sub = 1'b1; b_clr = 1'b1; clr_bstart = 1'b1; next = ENTER_B;
          end else if (bus.key_i == KEY_BS) a_bs = 1'b1;
        end
        ENTER_B: begin
          if (dig) begin
            b_shift = 1'b1; set_bstart = 1'b1;
          end else if (op) begin
            // operator may be changed only before B has any digits
            if (!b_started) set_sub = 1'b1;
          end else if (bus.key_i == KEY_EQ) begin
            cap_res = 1'b1;
            next    = err ? SHOW_ERR : SHOW_RES;
          end else if (bus.key_i == KEY_BS) b_bs = 1'b1;
        end
        SHOW_RES, SHOW_ERR: begin
          if (dig) begin
            // new calculation starts with this digit
            a_load = 1'b1; a_load_val = {12'h0, bus.key_i}; b_clr = 1'b1;
            next = ENTER_A;
          end else if (op && state == SHOW_RES) begin
            // chain: result becomes the new A
            a_load = 1'b1; set_sub = 1'b1; b_clr = 1'b1; clr_bstart = 1'b1;
            next = ENTER_B;
          end
        end
        default: next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_all) begin
      sub       <= 1'b0;
      b_started <= 1'b0;
      res       <= '0;
    end else begin
      if (set_sub)         sub <= (bus.key_i == KEY_SUB);
      if (set_bstart)      b_started <= 1'b1;
      else if (clr_bstart) b_started <= 1'b0;
      if (cap_res)         res <= sub ? bus.diff_i : bus.sum_i;
    end
  end

  bcd_entry_reg u_a (
    .clk(clk_i), .rst(rst_i), .clr(clr_all),
    .load_en(a_load), .load_val(a_load_val),
    .shift_en(a_shift), .digit(bus.key_i), .bs_en(a_bs),
    .q(a), .full(a_full)
  );

  bcd_entry_reg u_b (
    .clk(clk_i), .rst(rst_i), .clr(clr_all || b_clr),
    .load_en(1'b0), .load_val(16'h0),
    .shift_en(b_shift), .digit(bus.key_i), .bs_en(b_bs),
    .q(b), .full(b_full)
  );

  assign bus.a_o   = a;
  assign bus.b_o   = b;
  assign bus.sub_o = sub;

  // display value and leading-zero blanking; ones digit is never blanked
  logic [15:0] disp;
  logic        bl1000, bl100, bl10;

  always_comb begin
    unique case (state)
      ENTER_A:  disp = a;
      ENTER_B:  disp = b_started ? b : a;
      default:  disp = res;
    endcase
  end

  assign bl1000 = (disp[15:12] == 4'h0);
  assign bl100  = bl1000 && (disp[11:8] == 4'h0);
  assign bl10   = bl100  && (disp[7:4]  == 4'h0);

  always_comb begin
    if (state == SHOW_ERR) begin
      bus.dig1000_o = DIG_ERR;
      bus.dig100_o  = DIG_ERR;
      bus.dig10_o   = DIG_ERR;
      bus.dig1_o    = DIG_ERR;
    end else begin
      bus.dig1000_o = bl1000 ? DIG_BLANK : disp[15:12];
      bus.dig100_o  = bl100  ? DIG_BLANK : disp[11:8];
      bus.dig10_o   = bl10   ? DIG_BLANK : disp[7:4];
      bus.dig1_o    = disp[3:0];
    end
  end

  // full flags are consumed inside the registers; kept visible for debug
  logic unused_full;
  assign unused_full = a_full ^ b_full;
endmodule

// File: tb/tb_calc_entry.sv
// Directed self-checking bench for calc_entry. The adder/subtractor chains
// are modelled from the DUT's operand outputs; expected values are constants.
module tb_calc_entry;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  calc_entry_if bif ();

  calc_entry dut (.clk_i(clk), .rst_i(rst), .bus(bif.slave));

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] v);
    return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  // external BCD arithmetic chains
  int av, bv;
  always_comb begin
    av = bcd2int(bif.a_o);
    bv = bcd2int(bif.b_o);
    bif.sum_i    = int2bcd((av + bv) % 10000);
    bif.carry_i  = (av + bv) > 9999;
    bif.diff_i   = int2bcd((av - bv + 10000) % 10000);
    bif.borrow_i = av < bv;
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bif.key_i = k;
    bif.key_valid_i = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bif.key_i = 4'hF;
    bif.key_valid_i = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] disp();
    return {bif.dig1000_o, bif.dig100_o, bif.dig10_o, bif.dig1_o};
  endfunction

  initial begin
    bif.key_i = 4'hF;
    bif.key_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a", bif.a_o, 16'h0000);
    chk("rst_b", bif.b_o, 16'h0000);
    chk("rst_sub", {15'h0, bif.sub_o}, 16'h0000);
    chk("rst_disp", disp(), 16'hFFF0);

    // 123 + 45 = 168, keys back to back
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    press(4'h4); press(4'h5); press(4'hC); idle();
    chk("add_a", bif.a_o, 16'h0123);
    chk("add_b", bif.b_o, 16'h0045);
    chk("add_sub", {15'h0, bif.sub_o}, 16'h0000);
    chk("add_disp", disp(), 16'hF168);

    // 9999 + 1 overflows
    press(4'h9); press(4'h9); press(4'h9); press(4'h9);
    press(4'hA); press(4'h1); press(4'hC); idle();
    chk("ovf_disp", disp(), 16'hEEEE);
    press(4'hE); press(4'hA); press(4'hC); idle();
    chk("err_ignore", disp(), 16'hEEEE);
    press(4'h2); idle();
    chk("err_dig_a", bif.a_o, 16'h0002);
    chk("err_dig_b", bif.b_o, 16'h0000);
    chk("err_dig_disp", disp(), 16'hFFF2);

    // 5 - 7 underflows; then 7 - 5 = 2
    press(4'hD);
    press(4'h5); press(4'hB); press(4'h7); press(4'hC); idle();
    chk("udf_disp", disp(), 16'hEEEE);
    press(4'h7); press(4'hB); press(4'h5); press(4'hC); idle();
    chk("sub_disp", disp(), 16'hFFF2);
    chk("sub_sub", {15'h0, bif.sub_o}, 16'h0001);

    // fifth digit dropped, backspace
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); idle();
    chk("full_a", bif.a_o, 16'h1234);
    chk("full_disp", disp(), 16'h1234);
    press(4'hE); idle();
    chk("bs_a", bif.a_o, 16'h0123);
    chk("bs_disp", disp(), 16'hF123);
    press(4'hE); press(4'hE); press(4'hE); press(4'hE); idle();
    chk("bs_zero_a", bif.a_o, 16'h0000);
    chk("bs_zero_disp", disp(), 16'hFFF0);

    // operator replacement, then chaining
    press(4'h8); press(4'hA); press(4'hB); idle();
    chk("oprep_sub", {15'h0, bif.sub_o}, 16'h0001);
    chk("oprep_disp", disp(), 16'hFFF8);
    press(4'h3); press(4'hA); idle();
    chk("bstart_lock", {15'h0, bif.sub_o}, 16'h0001);
    press(4'hC); idle();
    chk("oprep_res", disp(), 16'hFFF5);
    press(4'hA); idle();
    chk("chain_a", bif.a_o, 16'h0005);
    chk("chain_sub", {15'h0, bif.sub_o}, 16'h0000);
    press(4'h1); press(4'h0); press(4'hC); idle();
    chk("chain_b", bif.b_o, 16'h0010);
    chk("chain_disp", disp(), 16'hFF15);

    // reset wins over a simultaneous key strobe
    press(4'h4); press(4'h2); press(4'hA); idle();
    chk("pre_rst_a", bif.a_o, 16'h0042);
    @(negedge clk);
    bif.key_i = 4'h6;
    bif.key_valid_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bif.key_i = 4'hF;
    bif.key_valid_i = 1'b0;
    chk("mid_rst_a", bif.a_o, 16'h0000);
    chk("mid_rst_b", bif.b_o, 16'h0000);
    chk("mid_rst_sub", {15'h0, bif.sub_o}, 16'h0000);
    chk("mid_rst_disp", disp(), 16'hFFF0);
    press(4'h6); idle();
    chk("post_rst_a", bif.a_o, 16'h0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
